// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: default widths, the NOP word, instruction
// field positions and the fetch FSM state encoding.
package mips_pipe_pkg;

   localparam int INST_W = 19;
   localparam int PC_W   = 12;

   localparam logic [INST_W-1:0] NOP = '0;

   // Instruction field positions
   localparam int OPC_MSB = 18;
   localparam int OPC_LSB = 14;
   localparam int RD_MSB  = 13;
   localparam int RD_LSB  = 11;
   localparam int RS_MSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int RT_MSB  = 7;
   localparam int RT_LSB  = 5;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      REDIR = 2'd2
   } fetch_state_e;

   // What the IF/ID register does on the next edge
   typedef enum logic [2:0] {
      IFID_KEEP   = 3'd0,
      IFID_MEM    = 3'd1,
      IFID_BUF    = 3'd2,
      IFID_BUBBLE = 3'd3,
      IFID_NOP    = 3'd4
   } ifid_op_e;

   function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INST_W-1:0] inst);
      return inst[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [RD_MSB-RD_LSB:0] rd_of(input logic [INST_W-1:0] inst);
      return inst[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [RS_MSB-RS_LSB:0] rs_of(input logic [INST_W-1:0] inst);
      return inst[RS_MSB:RS_LSB];
   endfunction

   function automatic logic [RT_MSB-RT_LSB:0] rt_of(input logic [INST_W-1:0] inst);
      return inst[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {instruction, pc, valid} buffer that parks a word returned by
// instruction memory while decode is stalled. Clear wins over load.
module fetch_hold_buffer #(
   parameter int INST_W = mips_pipe_pkg::INST_W,
   parameter int PC_W   = mips_pipe_pkg::PC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [INST_W-1:0] load_instruction,
   input  logic [PC_W-1:0]   load_pc,
   output logic [INST_W-1:0] rd_instruction,
   output logic [PC_W-1:0]   rd_pc,
   output logic              rd_valid
);

   // Entry storage; a cleared entry keeps its stale data but is marked invalid
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_instruction <= '0;
         rd_pc          <= '0;
         rd_valid       <= 1'b0;
      end else if (clear) begin
         rd_valid <= 1'b0;
      end else if (load) begin
         rd_instruction <= load_instruction;
         rd_pc          <= load_pc;
         rd_valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, talks to instruction memory and
// fills the IF/ID pipeline register, honouring stall, flush and redirect.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | imem_req high; accept word at pc when imem_ready
// HOLD  | word captured during a stall waits in the hold buffer
// REDIR | one idle cycle after a redirect while the new address settles
module fetch_unit #(
   parameter int                 PC_W     = mips_pipe_pkg::PC_W,
   parameter int                 INST_W   = mips_pipe_pkg::INST_W,
   parameter logic [PC_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_writebar,
   input  logic              IF_ID_loadbar,
   input  logic              IF_ID_flush,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] IF_ID_instruction,
   output logic [PC_W-1:0]   IF_ID_pc,
   output logic              IF_ID_valid
);

   import mips_pipe_pkg::*;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   fetch_state_e        state, state_nxt;
   ifid_op_e            ifid_op;
   logic [PC_W-1:0]     pc_nxt;
   logic                stall;
   logic                hold_load;
   logic                hold_clear;
   logic [INST_W-1:0]   hold_instruction;
   logic [PC_W-1:0]     hold_pc;
   logic                hold_valid;

   assign stall     = pc_writebar | IF_ID_loadbar;
   assign imem_addr = pc;

   fetch_hold_buffer #(
      .INST_W (INST_W),
      .PC_W   (PC_W)
   ) u_hold (
      .clk              (clk),
      .reset            (reset),
      .load             (hold_load),
      .clear            (hold_clear),
      .load_instruction (imem_rdata),
      .load_pc          (pc),
      .rd_instruction   (hold_instruction),
      .rd_pc            (hold_pc),
      .rd_valid         (hold_valid)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, next pc, memory request and IF/ID / hold-buffer controls
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      imem_req   = 1'b0;
      ifid_op    = IFID_KEEP;
      hold_load  = 1'b0;
      hold_clear = 1'b0;

      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if (stall) begin
                  hold_load = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  ifid_op = IFID_MEM;
                  pc_nxt  = pc + PC_ONE;
               end
            end else if (!stall) begin
               ifid_op = IFID_BUBBLE;
            end
         end
         HOLD: begin
            if (!stall) begin
               ifid_op    = IFID_BUF;
               pc_nxt     = pc + PC_ONE;
               hold_clear = 1'b1;
               state_nxt  = FETCH;
            end
         end
         REDIR: begin
            state_nxt = FETCH;
            if (!stall) begin
               ifid_op = IFID_BUBBLE;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase

      // Flush kills whatever IF/ID would otherwise have done this cycle
      if (IF_ID_flush) begin
         ifid_op = IFID_NOP;
      end

      // Redirect outranks everything: returning data and any parked word
      // belong to the wrong path, so nothing from memory reaches IF/ID
      if (redirect_valid) begin
         pc_nxt     = redirect_pc;
         hold_load  = 1'b0;
         hold_clear = 1'b1;
         state_nxt  = REDIR;
         if (IF_ID_flush) begin
            ifid_op = IFID_NOP;
         end else if (stall) begin
            ifid_op = IFID_KEEP;
         end else begin
            ifid_op = IFID_BUBBLE;
         end
      end
   end

   // Program counter
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_nxt;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (reset) begin
         IF_ID_instruction <= '0;
         IF_ID_pc          <= '0;
         IF_ID_valid       <= 1'b0;
      end else begin
         case (ifid_op)
            IFID_MEM: begin
               IF_ID_instruction <= imem_rdata;
               IF_ID_pc          <= pc;
               IF_ID_valid       <= 1'b1;
            end
            IFID_BUF: begin
               IF_ID_instruction <= hold_instruction;
               IF_ID_pc          <= hold_pc;
               IF_ID_valid       <= hold_valid;
            end
            IFID_BUBBLE: begin
               IF_ID_valid <= 1'b0;
            end
            IFID_NOP: begin
               IF_ID_instruction <= '0;
               IF_ID_valid       <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 12, SHALL set program-counter and instruction-address width.
REQ-002 Parameter INST_W, default 19, SHALL set instruction width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 pc_writebar  in  1  SHALL mean hold PC; no advance this cycle.
REQ-007 IF_ID_loadbar  in  1  SHALL mean hold the IF/ID register contents.
REQ-008 IF_ID_flush  in  1  SHALL mean replace the IF/ID contents with NOP.
REQ-009 redirect_valid  in  1  SHALL mean a taken branch or jump; load redirect_pc.
REQ-010 redirect_pc  in  PC_W  SHALL be the branch/jump target address.
REQ-011 imem_req  out  1  SHALL request an instruction read at imem_addr.
REQ-012 imem_addr  out  PC_W  SHALL be the read address; always equals pc.
REQ-013 imem_ready  in  1  SHALL mean imem_rdata is valid for the current-cycle imem_addr.
REQ-014 imem_rdata  in  INST_W  SHALL be the instruction word.
REQ-015 pc  out  PC_W  SHALL be the current fetch PC.
REQ-016 IF_ID_instruction  out  INST_W  SHALL be the registered instruction for decode.
REQ-017 IF_ID_pc  out  PC_W  SHALL be the PC of IF_ID_instruction.
REQ-018 IF_ID_valid  out  1  SHALL be 1 when IF_ID_instruction is a real fetched word.

Function
REQ-019 Stall SHALL be defined as pc_writebar OR IF_ID_loadbar.
REQ-020 The FSM SHALL have three states: FETCH, HOLD, REDIR. Reset state SHALL be FETCH.
REQ-021 In FETCH: imem_req=1. With imem_ready=1 and no stall, IF/ID SHALL load {imem_rdata, pc, valid=1}, pc SHALL become pc+1, and the state SHALL remain FETCH.
REQ-022 In FETCH: with imem_ready=1 and a stall, imem_rdata and pc SHALL be captured in a one-entry hold buffer, pc and IF/ID SHALL be unchanged, and the state SHALL go to HOLD.
REQ-023 In FETCH: with imem_ready=0, pc SHALL be unchanged and IF/ID SHALL be unchanged. IF_ID_valid SHALL drop to 0 only if no stall is active (bubble insertion).
REQ-024 In HOLD: imem_req=0. When stall deasserts, IF/ID SHALL load from the hold buffer, pc SHALL become pc+1, and the state SHALL go to FETCH. Latency from stall release to IF/ID update SHALL be 1 cycle.
REQ-025 Redirect: when redirect_valid=1 in any state, pc SHALL be set to redirect_pc, the hold buffer SHALL be invalidated, and the state SHALL go to REDIR. Any imem data arriving in that cycle SHALL be discarded.
REQ-026 In REDIR: imem_req=0 for one cycle (address settle), then the state SHALL go to FETCH. A redirect_valid asserted during REDIR SHALL reload pc and stay in REDIR.
REQ-027 IF_ID_flush=1 SHALL set IF_ID_instruction to NOP (all zero), IF_ID_valid to 0, and IF_ID_pc to unchanged. Flush SHALL override both load and hold.
REQ-028 Priority SHALL be: reset > redirect_valid > IF_ID_flush > stall > normal advance.
REQ-029 A simultaneous redirect_valid and stall SHALL take the redirect; pc_writebar SHALL NOT block the redirect.
REQ-030 PC arithmetic SHALL be modulo 2^PC_W; 0xFFF+1 SHALL wrap to 0x000 with no flag.
REQ-031 imem_addr SHALL equal pc combinationally in every state.

Reset
REQ-032 On reset: pc=RESET_PC, state=FETCH, hold buffer invalid, IF_ID_instruction=0, IF_ID_pc=0, IF_ID_valid=0.
REQ-033 Reset mid-HOLD or mid-REDIR SHALL discard all pending state; imem_req SHALL be 1 on the first cycle after reset is released.

Structure
REQ-034 The shared package mips_pipe_pkg SHALL hold INST_W, PC_W, the NOP constant, the opcode field slices ([18:14] opcode, [13:11] rd, [10:8] rs, [7:5] rt) and the FSM state enumeration.
REQ-035 The block SHALL contain one sub-module, fetch_hold_buffer: a one-entry {instruction, pc, valid} register with load, clear, and read ports.

Verification
REQ-036 Straight-line fetch: imem_ready always 1, no stall -> pc goes 0,1,2,3; IF_ID_pc lags pc by 1; IF_ID_valid=1 from cycle 2 onward.
REQ-037 Load-use stall: pc_writebar=IF_ID_loadbar=1 for 1 cycle at pc=5 -> IF_ID holds PC 4; word 5 is held and delivered the cycle after release; no word is lost or duplicated.
REQ-038 Taken branch: redirect_valid=1, redirect_pc=0x040, with IF_ID_flush=1 -> IF_ID_valid=0; imem_req=0 for 1 cycle; next fetch address is 0x040.
REQ-039 Redirect during HOLD: stall active with buffer full, then redirect_pc=0x010 -> buffered word is never emitted; first valid IF_ID_pc is 0x010.
REQ-040 Memory wait plus wrap: pc=0xFFF with imem_ready low for 3 cycles -> 3 bubbles (IF_ID_valid=0); then IF_ID_pc=0xFFF and pc=0x000.
REQ-041 Reset asserted in HOLD -> next cycle pc=RESET_PC, IF_ID_valid=0, imem_req=1.
